// File: rtl/imm_pkg.sv
// Shared types for the immediate-generation stage.
//   imm_sel_e : immediate format select driven by the decoder.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_U     = 3'b011,
    IMM_J     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_ZIMM  = 3'b110,
    IMM_RSVD  = 3'b111
  } imm_sel_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extractor.
//   instr : raw 32-bit instruction
//   sel   : format select
//   imm   : immediate extended to XLEN
//   err   : sel was the reserved encoding (imm forced to zero)
module imm_extract
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_sel_e        sel,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  // Opcode bits never contribute to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm = '0;
    err = 1'b0;
    case (sel)
      IMM_I:     imm = XLEN'($signed(instr[31:20]));
      IMM_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B:     imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_U:     imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_J:     imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_SHAMT: imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
      IMM_ZIMM:  imm = XLEN'(instr[19:15]);
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate generator: extractor followed by a registered
// valid/ready stage with a one-entry skid register (two entries total).
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : upstream handshake; instr, imm_sel, in_tag payload
//   out_valid/out_ready : downstream handshake; imm, out_tag, imm_err payload
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             imm_err
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("imm_extend_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  ext_imm;
  logic             ext_err;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_err;

  logic             accept;
  logic             out_load;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr (instr),
    .sel   (imm_sel_e'(imm_sel)),
    .imm   (ext_imm),
    .err   (ext_err)
  );

  assign in_ready = !skid_valid && !reset;
  assign accept   = in_valid && in_ready;
  // Output register may take new data when empty or being drained this cycle.
  assign out_load = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      imm        <= '0;
      out_tag    <= '0;
      imm_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_tag   <= '0;
      skid_err   <= 1'b0;
    end else if (out_load) begin
      // Skid holds the older entry, so it takes priority; accept is
      // impossible while skid is full because in_ready is low.
      if (skid_valid) begin
        out_valid  <= 1'b1;
        imm        <= skid_imm;
        out_tag    <= skid_tag;
        imm_err    <= skid_err;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid  <= 1'b1;
        imm        <= ext_imm;
        out_tag    <= in_tag;
        imm_err    <= ext_err;
      end else begin
        out_valid  <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_imm   <= ext_imm;
      skid_tag   <= in_tag;
      skid_err   <= ext_err;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_sel;
  logic [7:0]  in_tag;
  logic        out_ready;

  logic        rdy32, ov32, err32;
  logic [31:0] imm32;
  logic [7:0]  tag32;
  logic        rdy64, ov64, err64;
  logic [63:0] imm64;
  logic [7:0]  tag64;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [31:0] w;
    logic [2:0]  sel;
    logic [7:0]  tag;
  } entry_t;

  entry_t q[$];

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .TAG_W(8)) u32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
    .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .imm(imm32),
    .out_tag(tag32), .imm_err(err32)
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(8)) u64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
    .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready), .imm(imm64),
    .out_tag(tag64), .imm_err(err64)
  );

  // Reference immediate straight from the format definitions.
  function automatic logic [63:0] ref_imm(int unsigned xlen, logic [31:0] w, logic [2:0] sel);
    longint v;
    case (sel)
      3'd0:    v = longint'($signed(w[31:20]));
      3'd1:    v = longint'($signed({w[31:25], w[11:7]}));
      3'd2:    v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      3'd3:    v = longint'($signed(w[31:12])) * 64'sd4096;
      3'd4:    v = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      3'd5:    v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
      3'd6:    v = longint'(w[19:15]);
      default: v = 0;
    endcase
    if (xlen == 32) return {32'h0, v[31:0]};
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One clock cycle: drive, check against the FIFO model, advance the model.
  task automatic cyc(input bit iv, input logic [31:0] w, input logic [2:0] sel,
                     input logic [7:0] tg, input bit ordy, input bit rst);
    bit exp_rdy;
    @(negedge clk);
    in_valid  = iv;
    instr     = w;
    imm_sel   = sel;
    in_tag    = tg;
    out_ready = ordy;
    reset     = rst;
    #1;
    exp_rdy = !rst && (q.size() < 2);
    chk("in_ready32", {63'h0, rdy32}, {63'h0, exp_rdy});
    chk("in_ready64", {63'h0, rdy64}, {63'h0, exp_rdy});
    chk("out_valid32", {63'h0, ov32}, {63'h0, q.size() > 0});
    chk("out_valid64", {63'h0, ov64}, {63'h0, q.size() > 0});
    if (q.size() > 0) begin
      chk("imm32", {32'h0, imm32}, ref_imm(32, q[0].w, q[0].sel));
      chk("imm64", imm64, ref_imm(64, q[0].w, q[0].sel));
      chk("tag32", {56'h0, tag32}, {56'h0, q[0].tag});
      chk("tag64", {56'h0, tag64}, {56'h0, q[0].tag});
      chk("err32", {63'h0, err32}, {63'h0, q[0].sel == 3'b111});
      chk("err64", {63'h0, err64}, {63'h0, q[0].sel == 3'b111});
    end
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (ordy && q.size() > 0) void'(q.pop_front());
      if (iv && exp_rdy) q.push_back('{w: w, sel: sel, tag: tg});
    end
    #1;
  endtask

  task automatic chk_reset_payload();
    chk("rst_imm32", {32'h0, imm32}, 64'h0);
    chk("rst_imm64", imm64, 64'h0);
    chk("rst_tag", {56'h0, tag32}, 64'h0);
    chk("rst_err", {63'h0, err64}, 64'h0);
  endtask

  initial begin
    in_valid = 0; instr = '0; imm_sel = '0; in_tag = '0; out_ready = 0; reset = 1;

    cyc(0, 32'h0, 3'd0, 8'h0, 1, 1);
    cyc(0, 32'h0, 3'd0, 8'h0, 1, 1);
    chk_reset_payload();

    // I format, one-cycle latency
    cyc(1, 32'hFFF00093, 3'd0, 8'h01, 1, 0);
    chk("t1_imm32", {32'h0, imm32}, 64'h0000_0000_FFFF_FFFF);
    chk("t1_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc(0, 32'h0, 3'd0, 8'h0, 1, 0);

    // Back-to-back formats, no bubbles
    cyc(1, 32'hFE20AE23, 3'd1, 8'h01, 1, 0);
    chk("t2_s", {32'h0, imm32}, 64'hFFFF_FFFC);
    cyc(1, 32'hFE000CE3, 3'd2, 8'h02, 1, 0);
    chk("t2_b", {32'h0, imm32}, 64'hFFFF_FFF8);
    cyc(1, 32'h123452B7, 3'd3, 8'h03, 1, 0);
    chk("t2_u", {32'h0, imm32}, 64'h1234_5000);
    cyc(1, 32'h001000EF, 3'd4, 8'h04, 1, 0);
    chk("t2_j", {32'h0, imm32}, 64'h0000_0800);
    chk("t2_tag", {56'h0, tag32}, 64'h04);

    // 64-bit specifics
    cyc(1, 32'h800002B7, 3'd3, 8'h10, 1, 0);
    chk("t3_u64", imm64, 64'hFFFF_FFFF_8000_0000);
    cyc(1, 32'h03F00013, 3'd5, 8'h11, 1, 0);
    chk("t3_shamt64", imm64, 64'h3F);
    chk("t3_shamt32", {32'h0, imm32}, 64'h1F);
    cyc(1, 32'h000F8073, 3'd6, 8'h12, 1, 0);
    chk("t3_zimm64", imm64, 64'h1F);

    // Reserved select
    cyc(1, 32'hFFFFFFFF, 3'd7, 8'h5A, 1, 0);
    chk("t4_imm", imm64, 64'h0);
    chk("t4_err", {63'h0, err32}, 64'h1);
    chk("t4_tag", {56'h0, tag32}, 64'h5A);
    cyc(1, 32'hFFF00093, 3'd0, 8'h5B, 1, 0);
    chk("t4_next_err", {63'h0, err32}, 64'h0);

    // Backpressure: output holds, skid fills, in_ready drops, then drain
    cyc(1, 32'h00100093, 3'd0, 8'h20, 0, 0);
    cyc(1, 32'h00200093, 3'd0, 8'h21, 0, 0);
    cyc(1, 32'h00300093, 3'd0, 8'h22, 0, 0);
    cyc(1, 32'h00400093, 3'd0, 8'h23, 1, 0);
    cyc(1, 32'h00500093, 3'd0, 8'h24, 1, 0);
    cyc(0, 32'h0, 3'd0, 8'h0, 1, 0);
    cyc(0, 32'h0, 3'd0, 8'h0, 1, 0);
    cyc(0, 32'h0, 3'd0, 8'h0, 1, 0);

    // Reset with both entries full
    cyc(1, 32'h00600093, 3'd0, 8'h30, 0, 0);
    cyc(1, 32'h00700093, 3'd0, 8'h31, 0, 0);
    cyc(1, 32'h00800093, 3'd0, 8'h32, 0, 1);
    chk_reset_payload();
    cyc(1, 32'hFE20AE23, 3'd1, 8'h33, 1, 0);
    chk("t6_first_tag", {56'h0, tag64}, 64'h33);
    cyc(0, 32'h0, 3'd0, 8'h0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom, 3'($urandom_range(0, 7)),
          8'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 99) == 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 32'h0, 3'd0, 8'h0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
